// File: rtl/rv_pkg.sv
// Shared defaults and port-select encoding for the response path.
package rv_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned RESP_DEPTH     = 4;

  // Tag values recorded per request: which upstream port owns the response.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage : rv_pkg

// File: rtl/resp_tag_fifo.sv
// One-bit-wide tag FIFO recording which port each outstanding request came from.
module resp_tag_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = RESP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   din,
  input  logic                   pop,
  output logic                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] mem;
  logic             push_en;
  logic             pop_en;

  // Full/empty come from registered state only, so a same-cycle pop never frees a slot.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule : resp_tag_fifo

// File: rtl/resp_demux.sv
// Steers in-order memory responses to port 0 / port 1 using the recorded request tags.
// Optional sticky protocol-error flag: define RESP_DEMUX_ERR_EN.
module resp_demux
  import rv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = RESP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_fire,
  input  logic                   req_sel,
  output logic                   req_ready,
  input  logic                   rsp_valid,
  input  logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_ready,
  output logic                   out0_valid,
  output logic [DATA_W-1:0]      out0_data,
  input  logic                   out0_ready,
  output logic                   out1_valid,
  output logic [DATA_W-1:0]      out1_data,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] outstanding
`ifdef RESP_DEMUX_ERR_EN
  ,
  output logic                   err
`endif
);

  logic head;
  logic full;
  logic empty;
  logic rsp_fire;

  resp_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .din   (req_sel),
    .pop   (rsp_fire),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  // Zero-latency steering: data fans out to both ports, only the head port sees valid.
  assign req_ready  = ~full;
  assign out0_data  = rsp_data;
  assign out1_data  = rsp_data;
  assign out0_valid = rsp_valid & ~empty & (head == PORT_FETCH);
  assign out1_valid = rsp_valid & ~empty & (head == PORT_DATA);
  assign rsp_ready  = ~empty & ((head == PORT_DATA) ? out1_ready : out0_ready);
  assign rsp_fire   = rsp_valid & rsp_ready;

`ifdef RESP_DEMUX_ERR_EN
  // Sticky: response with nothing outstanding, or request issued while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((rsp_valid && empty) || (req_fire && full)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule : resp_demux

// File: tb/tb_resp_demux.sv
// Scoreboard bench for resp_demux: queue model of tags, in-order response checks.
module tb_resp_demux;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_fire;
  logic              req_sel;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic              out0_valid;
  logic [DATA_W-1:0] out0_data;
  logic              out0_ready;
  logic              out1_valid;
  logic [DATA_W-1:0] out1_data;
  logic              out1_ready;
  logic [2:0]        outstanding;
`ifdef RESP_DEMUX_ERR_EN
  logic              err;
`endif

  resp_demux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_fire    (req_fire),
    .req_sel     (req_sel),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .out0_valid  (out0_valid),
    .out0_data   (out0_data),
    .out0_ready  (out0_ready),
    .out1_valid  (out1_valid),
    .out1_data   (out1_data),
    .out1_ready  (out1_ready),
    .outstanding (outstanding)
`ifdef RESP_DEMUX_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int unsigned req_seq;
  int unsigned rsp_seq;
  bit          err_m;
  int          n_chk;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; combinational outputs checked mid-low-phase against the model.
  task automatic step(input logic f, input logic s, input logic rv, input logic r0, input logic r1);
    int   cnt;
    logic h;
    logic exp_rdy;
    ent_t e;
    @(negedge clk);
    req_fire   = f;
    req_sel    = s;
    rsp_valid  = rv;
    rsp_data   = 32'(rsp_seq);
    out0_ready = r0;
    out1_ready = r1;
    #1;
    cnt     = sb.size();
    h       = (cnt != 0) ? sb[0].sel : 1'b0;
    exp_rdy = (cnt != 0) && (h ? r1 : r0);
    check("req_ready",   32'(req_ready),   32'(cnt != DEPTH));
    check("outstanding", 32'(outstanding), 32'(cnt));
    check("rsp_ready",   32'(rsp_ready),   32'(exp_rdy));
    check("out0_valid",  32'(out0_valid),  32'(rv && cnt != 0 && !h));
    check("out1_valid",  32'(out1_valid),  32'(rv && cnt != 0 && h));
    check("out0_data",   out0_data,        rsp_data);
    check("out1_data",   out1_data,        rsp_data);
`ifdef RESP_DEMUX_ERR_EN
    check("err",         32'(err),         32'(err_m));
`endif
    if (rv && exp_rdy) begin
      e = sb.pop_front();
      check("xfer_port", 32'(out1_valid & r1), 32'(e.sel));
      check("xfer_data", e.sel ? out1_data : out0_data, e.data);
      rsp_seq++;
    end
    if (f && cnt < int'(DEPTH)) begin
      sb.push_back('{s, 32'(req_seq)});
      req_seq++;
    end
    if ((rv && cnt == 0) || (f && cnt == int'(DEPTH))) err_m = 1'b1;
  endtask

  task automatic model_reset();
    sb.delete();
    err_m   = 1'b0;
    rsp_seq = req_seq;
  endtask

  initial begin
    logic [3:0] pat;
    n_chk = 0; n_bad = 0;
    req_seq = 32'hA; rsp_seq = 32'hA; err_m = 1'b0;
    rst = 1'b1; req_fire = 1'b0; req_sel = 1'b0; rsp_valid = 1'b0;
    rsp_data = '0; out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset state, with a response and both readys offered.
    @(negedge clk);
    rsp_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    check("rst_req_ready",   32'(req_ready),   32'd1);
    check("rst_rsp_ready",   32'(rsp_ready),   32'd0);
    check("rst_out0_valid",  32'(out0_valid),  32'd0);
    check("rst_out1_valid",  32'(out1_valid),  32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    rsp_valid = 1'b0;
    rst = 1'b0;

    // Tags 0,1,1,0 then responses 0xA..0xD.
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Full boundary: 5th request ignored, full+pop keeps req_ready low, pop frees a slot.
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Backpressure on head port 1 while port 0 is ready.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Push into empty with a response in the same cycle: no bypass.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Count held at 2 across 10 simultaneous push/pop cycles (pointers wrap).
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(1)), 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("same_cycle_count", 32'(outstanding), 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Response while empty.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset with 3 tags outstanding.
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i), 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    req_fire = 1'b0; rsp_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    check("pre_arst_outstanding", 32'(outstanding), 32'd3);
    rst = 1'b1;
    #1;
    check("arst_outstanding", 32'(outstanding), 32'd0);
    check("arst_out0_valid",  32'(out0_valid),  32'd0);
    check("arst_out1_valid",  32'(out1_valid),  32'd0);
    check("arst_rsp_ready",   32'(rsp_ready),   32'd0);
    check("arst_req_ready",   32'(req_ready),   32'd1);
`ifdef RESP_DEMUX_ERR_EN
    check("arst_err",         32'(err),         32'd0);
`endif
    model_reset();
    rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Normal operation after reset.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_resp_demux

// File: doc/resp_demux.md
RESP_DEMUX -- requirements
Module: resp_demux

Interface
REQ-001 Parameter DATA_W, default 32: width of the response data path.
REQ-002 Parameter DEPTH, default 4: number of outstanding-request tags held; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_fire  input  1  a request from the upstream 2:1 request mux was issued to memory this cycle.
REQ-006 req_sel  input  1  requester that issued it (0 = port 0/fetch, 1 = port 1/data); sampled when req_fire=1.
REQ-007 req_ready  output  1  tag store can accept a request (not full).
REQ-008 rsp_valid  input  1  memory response valid.
REQ-009 rsp_data  input  DATA_W  memory response data.
REQ-010 rsp_ready  output  1  response accepted this cycle.
REQ-011 out0_valid / out1_valid  output  1 each  response valid toward port 0 / port 1.
REQ-012 out0_data / out1_data  output  DATA_W each  response data toward port 0 / port 1.
REQ-013 out0_ready / out1_ready  input  1 each  port 0 / port 1 can take a response.
REQ-014 outstanding  output  log2(DEPTH)+1  number of tags currently held.
REQ-015 err  output  1  sticky protocol-error flag; present only with RESP_DEMUX_ERR_EN.

Function
REQ-016 Push: req_fire=1 and req_ready=1 SHALL write req_sel at the write pointer, advance it modulo DEPTH and increment the count.
REQ-017 req_fire=1 while full SHALL be ignored: no state change, no tag stored.
REQ-018 req_ready SHALL equal (count != DEPTH), combinationally from registered state.
REQ-019 Head tag h = tag at the read pointer; valid only when count != 0.
REQ-020 outh_valid SHALL equal rsp_valid and (count != 0); the other port's valid SHALL be 0.
REQ-021 Both outK_data SHALL always carry rsp_data; this is zero-latency steering, no data register.
REQ-022 rsp_ready SHALL equal (count != 0) and outh_ready; ready of the non-head port SHALL be ignored.
REQ-023 Pop: rsp_valid=1 and rsp_ready=1 SHALL advance the read pointer modulo DEPTH and decrement the count.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged and move both pointers.
REQ-025 No bypass: a tag pushed in cycle N SHALL NOT route a response before cycle N+1; rsp_valid while empty SHALL get rsp_ready=0.
REQ-026 When full, a pop in the same cycle SHALL NOT enable a push; req_ready stays 0 in that cycle.
REQ-027 Responses SHALL be routed strictly in request order; both pointers wrap from DEPTH-1 to 0.
REQ-028 outstanding SHALL equal the registered count.

Reset
REQ-029 While rst=1, pointers, count and err SHALL be 0 and tag storage contents are don't-care.
REQ-030 During and after reset: req_ready=1, rsp_ready=0, out0_valid=out1_valid=0, outstanding=0.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding tags immediately, without waiting for a clock edge.

Configuration
REQ-032 Macro RESP_DEMUX_ERR_EN: when defined, err SHALL be set on any rising edge where rsp_valid=1 and count=0, or where req_fire=1 and count=DEPTH.
REQ-033 err SHALL then hold until rst; routing behaviour SHALL be identical with and without the macro.
REQ-034 Without the macro, the err port and its logic SHALL be absent.

Structure
REQ-035 Shared package rv_pkg SHALL hold DATA_W default, RESP_DEPTH default and the port-select encoding constants PORT_FETCH=0 and PORT_DATA=1.
REQ-036 The tag store SHALL be a sub-module resp_tag_fifo (1-bit wide, DEPTH deep) with push/pop/full/empty/count.
REQ-037 resp_demux SHALL contain only the steering and handshake logic.

Verification
REQ-038 Reset check: reset, then push sel 0,1,1,0, then rsp_valid with data 0xA,0xB,0xC,0xD and both readys=1 -> out0 gets 0xA then 0xD; out1 gets 0xB then 0xC; outstanding returns to 0.
REQ-039 Full boundary: push 4 tags -> req_ready=0, outstanding=4; a 5th req_fire is ignored; one pop -> req_ready=1 the next cycle.
REQ-040 Backpressure: head=1, out1_ready=0, out0_ready=1, rsp_valid=1 -> rsp_ready=0 and out0_valid=0; raising out1_ready -> accept and pop.
REQ-041 Same-cycle events: with count=2, simultaneous push and pop -> count stays 2, order preserved across pointer wrap (run 10 push/pop cycles).
REQ-042 Empty case: rsp_valid=1 with count=0 -> rsp_ready=0, no out valid, and (with RESP_DEMUX_ERR_EN) err=1 until rst.
REQ-043 Reset mid-operation: assert rst asynchronously with count=3 -> outstanding=0 and outK_valid=0 before the next clock edge.
